// File: rtl/puf_eval_ctrl.sv
// Butterfly-PUF evaluation controller: excite/relax/sample sequencing with a
// per-cell ones counter; define PUF_MAJORITY_EN to majority-vote NUM_EVAL samples.
module puf_eval_ctrl #(
  parameter int CELLS    = 8,
  parameter int SETTLE   = 4,
  parameter int RELAX    = 4,
  parameter int NUM_EVAL = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CELLS-1:0] resp_in,
  output logic             excite,
  output logic             en,
  output logic             pre,
  output logic             clr,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_rdy,
  output logic [CELLS-1:0] response,
  output logic [CELLS-1:0] unstable
);

`ifdef PUF_MAJORITY_EN
  localparam int E = NUM_EVAL;
`else
  localparam int E = 1;
`endif
  localparam int EVAL_W = (NUM_EVAL > 1) ? $clog2(NUM_EVAL) : 1;

  typedef enum logic [2:0] {S_IDLE, S_EXCITE, S_RELAX, S_SAMPLE, S_DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        phase_cnt;
  logic [EVAL_W-1:0] eval_cnt;
  logic              last_eval;
  logic              drv_excite;
  logic              drv_en;
  logic              drv_clr;
  logic              drv_busy;
  logic [2:0]        ones_cnt  [CELLS];
  logic [2:0]        ones_next [CELLS];
  logic [CELLS-1:0]  vote;

  assign last_eval = (eval_cnt == EVAL_W'(E - 1));

  // The preset line is never asserted by this controller.
  assign pre = 1'b1;

  always_comb begin
    next_state = state;
    drv_excite = 1'b0;
    drv_en     = 1'b0;
    drv_clr    = 1'b1;
    drv_busy   = 1'b0;
    case (state)
      S_IDLE:   if (start) next_state = S_EXCITE;
      S_EXCITE: begin
        if (abort) next_state = S_IDLE;
        else if (phase_cnt == 4'(SETTLE - 1)) next_state = S_RELAX;
      end
      S_RELAX: begin
        if (abort) next_state = S_IDLE;
        else if (phase_cnt == 4'(RELAX - 1)) next_state = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort) next_state = S_IDLE;
        else if (last_eval) next_state = S_DONE;
        else next_state = S_EXCITE;
      end
      S_DONE:   if (rsp_rdy) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    // Drives are registered from the next state so they line up with it.
    case (next_state)
      S_EXCITE: begin
        drv_excite = 1'b1;
        drv_en     = 1'b1;
        drv_clr    = 1'b0;
        drv_busy   = 1'b1;
      end
      S_RELAX: begin
        drv_clr  = 1'b0;
        drv_busy = 1'b1;
      end
      S_SAMPLE: drv_busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      excite    <= 1'b0;
      en        <= 1'b0;
      clr       <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= next_state;
      excite    <= drv_excite;
      en        <= drv_en;
      clr       <= drv_clr;
      busy      <= drv_busy;
      rsp_valid <= (next_state == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      eval_cnt  <= '0;
    end else begin
      if (next_state != state) phase_cnt <= '0;
      else if (state == S_EXCITE || state == S_RELAX) phase_cnt <= phase_cnt + 4'd1;
      if (next_state == S_IDLE) eval_cnt <= '0;
      else if (state == S_SAMPLE && next_state == S_EXCITE) eval_cnt <= eval_cnt + EVAL_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < CELLS; i++) begin
      ones_next[i] = ones_cnt[i] + {2'b00, resp_in[i]};
      vote[i]      = (ones_next[i] > 3'(E / 2));
    end
  end

  // Counts are dropped whenever the FSM heads back to IDLE (release or abort).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) ones_cnt[i] <= '0;
    end else if (next_state == S_IDLE) begin
      for (int i = 0; i < CELLS; i++) ones_cnt[i] <= '0;
    end else if (state == S_SAMPLE) begin
      for (int i = 0; i < CELLS; i++) ones_cnt[i] <= ones_next[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) response <= '0;
    else if (state == S_SAMPLE && next_state == S_DONE) response <= vote;
  end

`ifdef PUF_MAJORITY_EN
  logic [CELLS-1:0] split;

  always_comb begin
    for (int i = 0; i < CELLS; i++)
      split[i] = (ones_next[i] != 3'd0) && (ones_next[i] < 3'(E));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) unstable <= '0;
    else if (state == S_SAMPLE && next_state == S_DONE) unstable <= split;
  end
`else
  assign unstable = '0;
`endif

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: vector table, directed corner
// sequences and randomized runs scored against a bit-counting model.
module tb_puf_eval_ctrl;
  localparam int CELLS    = 8;
  localparam int SETTLE   = 4;
  localparam int RELAX    = 4;
  localparam int NUM_EVAL = 5;
`ifdef PUF_MAJORITY_EN
  localparam int E = NUM_EVAL;
`else
  localparam int E = 1;
`endif
  localparam int PERIOD  = SETTLE + RELAX + 1;
  localparam int LATENCY = E * PERIOD + 1;
  // Drive vectors are {excite, en, clr, pre, busy, rsp_valid}.
  localparam logic [5:0] IDLE_DRV = 6'b001100;
  localparam logic [5:0] DONE_DRV = 6'b001101;

  typedef logic [6:0][CELLS-1:0] seq_t;
  typedef struct packed {
    seq_t             smp;
    logic             noisy;
    logic [CELLS-1:0] exp_resp;
    logic [CELLS-1:0] exp_unst;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             rsp_rdy = 1'b0;
  logic [CELLS-1:0] resp_in = '0;
  logic             excite, en, pre, clr, busy, rsp_valid;
  logic [CELLS-1:0] response, unstable;
  int               n_checks = 0;
  int               n_fail = 0;

  puf_eval_ctrl #(
    .CELLS(CELLS), .SETTLE(SETTLE), .RELAX(RELAX), .NUM_EVAL(NUM_EVAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .resp_in(resp_in),
    .excite(excite), .en(en), .pre(pre), .clr(clr), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_rdy(rsp_rdy), .response(response), .unstable(unstable)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] cur_drv();
    return {excite, en, clr, pre, busy, rsp_valid};
  endfunction

  // Cycle c counts from the cycle in which start is first held high (c = 0).
  function automatic logic [5:0] exp_drive(input int c);
    int p;
    if (c >= LATENCY) return DONE_DRV;
    p = (c - 1) % PERIOD;
    if (p < SETTLE) return 6'b110110;
    if (p < SETTLE + RELAX) return 6'b000110;
    return 6'b001110;
  endfunction

  function automatic seq_t seq5(input logic [CELLS-1:0] a, b, c, d, e);
    seq_t s;
    s = '0;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d; s[4] = e;
    return s;
  endfunction

  // Reference: count ones per cell over the E samples and vote.
  function automatic logic [2*CELLS-1:0] model(input seq_t smp);
    logic [CELLS-1:0] r, u;
    int ones;
    for (int b = 0; b < CELLS; b++) begin
      ones = 0;
      for (int k = 0; k < E; k++) ones += int'(smp[k][b]);
`ifdef PUF_MAJORITY_EN
      r[b] = (2 * ones > E);
      u[b] = (ones != 0) && (ones != E);
`else
      r[b] = (ones == 1);
      u[b] = 1'b0;
`endif
    end
    return {r, u};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One full request: pulse start, feed smp[k] for evaluation k (noise elsewhere
  // when noisy), check every drive cycle, latency and result, hold DONE for
  // 'hold' cycles (optionally poking start), then release with one rsp_rdy.
  task automatic applyStimulus(input string tag, input seq_t smp, input bit noisy, input int hold,
                               input bit poke, input logic [CELLS-1:0] exp_resp,
                               input logic [CELLS-1:0] exp_unst);
    int lat;
    int k;
    lat = -1;
    start = 1'b1;
    rsp_rdy = 1'b0;
    abort = 1'b0;
    resp_in = noisy ? CELLS'($urandom) : smp[0];
    for (int c = 1; c <= LATENCY + 5 && lat < 0; c++) begin
      tick();
      start = 1'b0;
      k = (c - 1) / PERIOD;
      if (k >= E) k = E - 1;
      resp_in = (!noisy || c == (k + 1) * PERIOD) ? smp[k] : CELLS'($urandom);
      @(negedge clk);
      if (rsp_valid === 1'b1) lat = c;
      else checkOutput($sformatf("%s drive c%0d", tag, c), 32'(cur_drv()), 32'(exp_drive(c)));
    end
    checkOutput({tag, " latency"}, lat, LATENCY);
    if (lat < 0) return;
    checkOutput({tag, " response"}, 32'(response), 32'(exp_resp));
    checkOutput({tag, " unstable"}, 32'(unstable), 32'(exp_unst));
    for (int d = 0; d < hold; d++) begin
      tick();
      start = poke ? d[0] : 1'b0;
      if (noisy) resp_in = CELLS'($urandom);
      @(negedge clk);
      checkOutput($sformatf("%s hold d%0d", tag, d), {cur_drv(), response, unstable},
                  {DONE_DRV, exp_resp, exp_unst});
    end
    tick();
    start = 1'b0;
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    @(negedge clk);
    checkOutput({tag, " release"}, 32'(cur_drv()), 32'(IDLE_DRV));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got no end, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [6];
    seq_t rs;
    logic [2*CELLS-1:0] m;
    int abort_c;
    int run_len;
    int runs;

`ifdef PUF_MAJORITY_EN
    vecs[0] = '{seq5(8'hA5, 8'hA5, 8'h5A, 8'hA5, 8'h5A), 1'b0, 8'hA5, 8'hFF};
    vecs[1] = '{seq5(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b1, 8'hFF, 8'h00};
    vecs[2] = '{seq5(8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00), 1'b1, 8'h00, 8'hFF};
    vecs[3] = '{seq5(8'h0F, 8'h0F, 8'h0F, 8'hF0, 8'hF0), 1'b1, 8'h0F, 8'hFF};
    vecs[4] = '{seq5(8'h81, 8'h81, 8'h81, 8'h81, 8'h01), 1'b1, 8'h81, 8'h80};
    vecs[5] = '{seq5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 8'h00, 8'h00};
`else
    vecs[0] = '{seq5(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5), 1'b0, 8'hA5, 8'h00};
    vecs[1] = '{seq5(8'h3C, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 8'h3C, 8'h00};
    vecs[2] = '{seq5(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 8'hFF, 8'h00};
    vecs[3] = '{seq5(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b1, 8'h00, 8'h00};
    vecs[4] = '{seq5(8'h01, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 8'h01, 8'h00};
    vecs[5] = '{seq5(8'h80, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 8'h80, 8'h00};
`endif

    $display("[TB] reset state");
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset drives", 32'(cur_drv()), 32'(IDLE_DRV));
    checkOutput("reset response", 32'(response), 32'h0);
    checkOutput("reset unstable", 32'(unstable), 32'h0);
    #20 rst_n = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("idle after reset", 32'(cur_drv()), 32'(IDLE_DRV));

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].smp, vecs[i].noisy, 0, 1'b0,
                    vecs[i].exp_resp, vecs[i].exp_unst);

    $display("[TB] DONE hold with start pokes");
    rs = seq5(8'h5A, 8'h5A, 8'hC3, 8'h5A, 8'hC3);
    m = model(rs);
    applyStimulus("hold", rs, 1'b1, 20, 1'b1, m[2*CELLS-1:CELLS], m[CELLS-1:0]);

    $display("[TB] abort in second relax cycle");
    abort_c = (E - 1) * PERIOD + SETTLE + 2;
    tick();
    start = 1'b1;
    resp_in = '1;
    for (int c = 1; c <= abort_c; c++) begin
      tick();
      start = 1'b0;
      abort = (c == abort_c);
      @(negedge clk);
      checkOutput($sformatf("abort drive c%0d", c), 32'(cur_drv()), 32'(exp_drive(c)));
    end
    tick();
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort idle", 32'(cur_drv()), 32'(IDLE_DRV));
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      checkOutput($sformatf("abort quiet %0d", c), 32'(cur_drv()), 32'(IDLE_DRV));
    end
    applyStimulus("after_abort", seq5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0, 0, 1'b0,
                  8'h00, 8'h00);

    $display("[TB] async reset during excite");
    applyStimulus("pre_reset", vecs[0].smp, vecs[0].noisy, 0, 1'b0, vecs[0].exp_resp,
                  vecs[0].exp_unst);
    tick();
    start = 1'b1;
    resp_in = 8'hA5;
    tick();
    start = 1'b0;
    tick();
    #1;
    checkOutput("rst excite before", 32'(excite), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst async drives", 32'(cur_drv()), 32'(IDLE_DRV));
    checkOutput("rst async response", 32'(response), 32'h0);
    checkOutput("rst async unstable", 32'(unstable), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst release idle", 32'(cur_drv()), 32'(IDLE_DRV));
    tick();
    @(negedge clk);
    checkOutput("rst stays idle", 32'(cur_drv()), 32'(IDLE_DRV));

    $display("[TB] start held across release");
    tick();
    start = 1'b1;
    rsp_rdy = 1'b0;
    resp_in = 8'h3C;
    run_len = 0;
    runs = 0;
    for (int c = 1; c <= 2 * LATENCY + 3; c++) begin
      tick();
      if (c == LATENCY + 1) rsp_rdy = 1'b1;
      if (c == LATENCY + 2) rsp_rdy = 1'b0;
      if (c == LATENCY + 3) start = 1'b0;
      if (c == 2 * LATENCY + 2) rsp_rdy = 1'b1;
      @(negedge clk);
      if (excite === 1'b1) run_len++;
      else if (run_len > 0) begin
        runs++;
        checkOutput($sformatf("held excite run %0d", runs), run_len, SETTLE);
        run_len = 0;
      end
      if (c == LATENCY) checkOutput("held done1", 32'(cur_drv()), 32'(DONE_DRV));
      if (c == LATENCY + 2) checkOutput("held idle", 32'(cur_drv()), 32'(IDLE_DRV));
      if (c == LATENCY + 3) checkOutput("held restart", 32'(cur_drv()), 32'(exp_drive(1)));
      if (c == 2 * LATENCY + 2) checkOutput("held done2", 32'(cur_drv()), 32'(DONE_DRV));
      if (c == 2 * LATENCY + 3) checkOutput("held final idle", 32'(cur_drv()), 32'(IDLE_DRV));
    end
    rsp_rdy = 1'b0;
    checkOutput("held excite runs", runs, 2 * E);

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 7; k++) rs[k] = CELLS'($urandom);
      if (r % 3 == 1) for (int k = 1; k < 7; k++) rs[k] = rs[0];
      m = model(rs);
      applyStimulus($sformatf("rand%0d", r), rs, 1'b1, $urandom_range(0, 3), 1'b1,
                    m[2*CELLS-1:CELLS], m[CELLS-1:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CELLS, 8, number of butterfly cells in the bank
- SETTLE, 4, cycles the excite phase is held (1..15)
- RELAX, 4, cycles the relax phase is held (1..15)
- NUM_EVAL, 5, evaluations per request; odd, 1..7; used only with PUF_MAJORITY_EN
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, request an evaluation; accepted only in IDLE
- abort, in, 1, synchronous cancel of any evaluation in progress
- resp_in, in, CELLS, q1 outputs of the cell bank
- excite, out, 1, excite drive to all cells
- en, out, 1, enable drive to all cells
- pre, out, 1, preset drive to all cells, active-low
- clr, out, 1, clear drive to all cells, active-low
- busy, out, 1, evaluation in progress
- rsp_valid, out, 1, response available
- rsp_rdy, in, 1, consumer accepts response
- response, out, CELLS, evaluated response word
- unstable, out, CELLS, per-bit disagreement flag
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 The FSM SHALL have the states IDLE, EXCITE, RELAX, SAMPLE and DONE.
REQ-005 IDLE SHALL transition to EXCITE on start=1; busy SHALL be 1 in every state except IDLE and DONE.
REQ-006 EXCITE SHALL last exactly SETTLE cycles with excite=1, en=1, clr=0, pre=1.
REQ-007 RELAX SHALL last exactly RELAX cycles with excite=0, en=0, clr=0, pre=1.
REQ-008 In IDLE, SAMPLE and DONE the drives SHALL be excite=0, en=0, clr=1, pre=1.
REQ-009 SAMPLE SHALL last 1 cycle and capture resp_in at its closing edge.
REQ-010 After SAMPLE, the FSM SHALL go to EXCITE if evaluations done < NUM_EVAL, otherwise to DONE.
REQ-011 In DONE, rsp_valid SHALL be 1, and response and unstable SHALL be held stable.
REQ-012 DONE SHALL transition to IDLE on the cycle where rsp_valid=1 and rsp_rdy=1; the per-bit counters SHALL clear on that transition.
REQ-013 start outside IDLE SHALL be ignored; no request queuing.
REQ-014 abort=1 in EXCITE, RELAX or SAMPLE SHALL force IDLE next cycle, discard partial counts and leave rsp_valid=0.
REQ-015 abort in IDLE or DONE SHALL be ignored.
REQ-016 If abort and start are both 1 in IDLE, start SHALL win.
REQ-017 Latency from the start edge to rsp_valid=1 SHALL be E*(SETTLE+RELAX+1)+1 cycles, where E is the evaluation count.
REQ-018 Each cell bit SHALL have a 3-bit ones-counter, incremented in SAMPLE when resp_in[i]=1; it SHALL never wrap for NUM_EVAL<=7.

Reset
REQ-019 While rst_n=0, the block SHALL asynchronously set state=IDLE, excite=0, en=0, clr=1, pre=1, busy=0, rsp_valid=0, response=0, unstable=0, and all counters to 0.
REQ-020 Reset asserted mid-evaluation SHALL abandon it; the first cycle after deassertion SHALL be IDLE.

Configuration
REQ-021 Macro PUF_MAJORITY_EN, when defined, SHALL set E=NUM_EVAL.
- response[i] SHALL be 1 iff count[i] > NUM_EVAL/2 (integer division).
- unstable[i] SHALL be 1 iff 0 < count[i] < NUM_EVAL.
REQ-022 When PUF_MAJORITY_EN is undefined, the block SHALL set E=1, response=resp_in as captured in SAMPLE, and unstable tied to 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- No macro, defaults, resp_in=8'hA5 constant, start pulse -> rsp_valid=1 exactly 10 cycles after the start edge, response=8'hA5, unstable=8'h00.
- PUF_MAJORITY_EN, NUM_EVAL=5, resp_in per SAMPLE = A5,A5,5A,A5,5A -> rsp_valid after 46 cycles, response=8'hA5, unstable=8'hFF.
- rsp_rdy=0 for 20 cycles in DONE -> rsp_valid and response held; start pulses ignored; one rsp_rdy=1 cycle -> IDLE next cycle.
- abort in the 2nd RELAX cycle -> IDLE next cycle, rsp_valid stays 0, drives at idle values; a new start gives a full-latency result.
- rst_n low during EXCITE -> outputs reach reset values immediately, without waiting for clk.
- start held high across DONE->IDLE -> a second evaluation begins the cycle after IDLE is entered; excite high for exactly SETTLE cycles per evaluation.
